// File: rtl/led_status_pkg.sv
// Shared types for the front-panel LED status controller.
// Provides the per-channel mode encoding and the fixed field widths of the
// configuration interface.
package led_status_pkg;

  localparam int unsigned MODE_W      = 2;
  localparam int unsigned BURST_CNT_W = 4;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } led_mode_e;

endpackage

// File: rtl/led_channel.sv
// One LED indicator channel: holds mode, half-period and burst count, and
// produces a registered LED drive plus a burst-in-progress flag.
// Ports:
//   ck, rstn  - clock, async active-low reset
//   tick_i    - shared prescaler tick (one cycle)
//   we_i      - config write for this channel (one cycle, wins over tick_i)
//   mode_i    - requested mode (led_mode_e encoding)
//   per_i     - half-period in ticks (0 behaves as 1)
//   cnt_i     - burst pulse count
//   led_o     - LED drive, active high
//   busy_o    - channel is executing a burst
module led_channel
  import led_status_pkg::*;
#(
  parameter int unsigned PER_W = 8
) (
  input  logic                   ck,
  input  logic                   rstn,
  input  logic                   tick_i,
  input  logic                   we_i,
  input  logic [MODE_W-1:0]      mode_i,
  input  logic [PER_W-1:0]       per_i,
  input  logic [BURST_CNT_W-1:0] cnt_i,
  output logic                   led_o,
  output logic                   busy_o
);

  led_mode_e              mode_q, mode_d;
  logic [PER_W-1:0]       per_q, per_d;
  logic [BURST_CNT_W-1:0] cnt_q, cnt_d;
  logic [PER_W-1:0]       tcnt_q, tcnt_d;
  logic [BURST_CNT_W-1:0] pcnt_q, pcnt_d;
  logic                   led_q, led_d;
  logic                   busy_q, busy_d;
  logic                   phase_end_c;

  // A phase ends on the tick that completes per_q ticks; per_q is never 0.
  assign phase_end_c = tick_i && (tcnt_q == per_q - PER_W'(1));

  // State register.
  always_ff @(posedge ck or negedge rstn) begin
    if (!rstn) begin
      mode_q <= MODE_OFF;
      per_q  <= PER_W'(1);
      cnt_q  <= '0;
      tcnt_q <= '0;
      pcnt_q <= '0;
      led_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      per_q  <= per_d;
      cnt_q  <= cnt_d;
      tcnt_q <= tcnt_d;
      pcnt_q <= pcnt_d;
      led_q  <= led_d;
      busy_q <= busy_d;
    end
  end

  // Next-state: a write reloads everything; otherwise ticks advance the phase.
  always_comb begin
    mode_d = mode_q;
    per_d  = per_q;
    cnt_d  = cnt_q;
    tcnt_d = tcnt_q;
    pcnt_d = pcnt_q;
    led_d  = led_q;
    busy_d = busy_q;

    if (we_i) begin
      per_d  = (per_i == '0) ? PER_W'(1) : per_i;
      cnt_d  = cnt_i;
      tcnt_d = '0;
      pcnt_d = '0;
      case (led_mode_e'(mode_i))
        MODE_OFF: begin
          mode_d = MODE_OFF;
          led_d  = 1'b0;
          busy_d = 1'b0;
        end
        MODE_ON: begin
          mode_d = MODE_ON;
          led_d  = 1'b1;
          busy_d = 1'b0;
        end
        MODE_BLINK: begin
          mode_d = MODE_BLINK;
          led_d  = 1'b1;
          busy_d = 1'b0;
        end
        MODE_BURST: begin
          // A zero-length burst completes at once and leaves the channel off.
          if (cnt_i == '0) begin
            mode_d = MODE_OFF;
            led_d  = 1'b0;
            busy_d = 1'b0;
          end else begin
            mode_d = MODE_BURST;
            led_d  = 1'b1;
            busy_d = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (tick_i && (mode_q == MODE_BLINK || mode_q == MODE_BURST)) begin
      if (!phase_end_c) begin
        tcnt_d = tcnt_q + PER_W'(1);
      end else begin
        tcnt_d = '0;
        if (mode_q == MODE_BLINK) begin
          led_d = ~led_q;
        end else if (led_q) begin
          led_d = 1'b0;
        end else if (pcnt_q == cnt_q - BURST_CNT_W'(1)) begin
          // End of the final low phase: burst complete.
          mode_d = MODE_OFF;
          busy_d = 1'b0;
          pcnt_d = '0;
        end else begin
          pcnt_d = pcnt_q + BURST_CNT_W'(1);
          led_d  = 1'b1;
        end
      end
    end
  end

  assign led_o  = led_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/led_status_ctrl.sv
// Front-panel status controller: shared tick prescaler, N_LED programmable
// indicator channels, and a synchronised/debounced push-button input.
// Ports:
//   ck, rstn  - clock, async active-low reset
//   cfg_we    - config write strobe; cfg_ch selects channel (out of range ignored)
//   cfg_mode  - 0 OFF, 1 ON, 2 BLINK, 3 BURST
//   cfg_per   - half-period in ticks; cfg_cnt - burst pulse count
//   sw_in     - raw active-low switch (asynchronous)
//   sw_level  - debounced switch level; sw_press - one-cycle press pulse
//   led       - LED drive, active high; busy - channel executing a burst
module led_status_ctrl
  import led_status_pkg::*;
#(
  parameter int unsigned N_LED     = 3,
  parameter int unsigned TICK_DIV  = 820000,
  parameter int unsigned PER_W     = 8,
  parameter int unsigned DEB_TICKS = 2,
  localparam int unsigned CH_W     = (N_LED > 1) ? $clog2(N_LED) : 1
) (
  input  logic                   ck,
  input  logic                   rstn,
  input  logic                   cfg_we,
  input  logic [CH_W-1:0]        cfg_ch,
  input  logic [MODE_W-1:0]      cfg_mode,
  input  logic [PER_W-1:0]       cfg_per,
  input  logic [BURST_CNT_W-1:0] cfg_cnt,
  input  logic                   sw_in,
  output logic                   sw_level,
  output logic                   sw_press,
  output logic [N_LED-1:0]       led,
  output logic [N_LED-1:0]       busy
);

  localparam int unsigned DIV_W = $clog2(TICK_DIV);
  localparam int unsigned DEB_W = $clog2(DEB_TICKS + 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_c;
  logic             sync1_q, sync2_q;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [N_LED-1:0] ch_we_c;

  assign tick_c = (div_q == DIV_W'(TICK_DIV - 1));

  // Prescaler, synchroniser and debounce registers.
  always_ff @(posedge ck or negedge rstn) begin
    if (!rstn) begin
      div_q   <= '0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= '0;
      level_q <= 1'b1;
      press_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      sync1_q <= sw_in;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  // Prescaler wrap and debounce: accept a new level after DEB_TICKS ticks
  // of uninterrupted disagreement with the current level.
  always_comb begin
    div_d   = tick_c ? '0 : div_q + DIV_W'(1);
    deb_d   = deb_q;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q == level_q) begin
      deb_d = '0;
    end else if (tick_c) begin
      if (deb_q == DEB_W'(DEB_TICKS - 1)) begin
        level_d = sync2_q;
        deb_d   = '0;
        press_d = ~sync2_q;
      end else begin
        deb_d = deb_q + DEB_W'(1);
      end
    end
  end

  assign sw_level = level_q;
  assign sw_press = press_q;

  // One channel per LED; a channel index with no instance simply never matches.
  for (genvar i = 0; i < N_LED; i++) begin : g_ch
    assign ch_we_c[i] = cfg_we && (cfg_ch == CH_W'(i));

    led_channel #(
      .PER_W(PER_W)
    ) u_ch (
      .ck    (ck),
      .rstn  (rstn),
      .tick_i(tick_c),
      .we_i  (ch_we_c[i]),
      .mode_i(cfg_mode),
      .per_i (cfg_per),
      .cnt_i (cfg_cnt),
      .led_o (led[i]),
      .busy_o(busy[i])
    );
  end

endmodule
